// File: rtl/mem_access_if.sv
// Request/acknowledge data bus between the memory-access stage and data memory.
interface mem_access_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: ALU/HI-LO passthrough, load/store over a req/ack bus
// with byte-lane selection, store replication, load extension and alignment traps.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic        mem_whilo,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        wb_whilo,
  output logic [31:0] wb_hi,
  output logic [31:0] wb_lo,
  output logic        stall_req,
  output logic        exc_adel,
  output logic        exc_ades,
  mem_access_if.master bus
);
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic is_load, is_store, is_mem, misaligned;

  function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_LB, OP_LBU, OP_SB: lane_sel = 4'b0001 << off;
      OP_LH, OP_LHU, OP_SH: lane_sel = off[1] ? 4'b1100 : 4'b0011;
      OP_LW, OP_SW:         lane_sel = 4'b1111;
      default:              lane_sel = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] sdata);
    case (op)
      OP_SB:   store_data = {4{sdata[7:0]}};
      OP_SH:   store_data = {2{sdata[15:0]}};
      default: store_data = sdata;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0]        lane;
    logic signed [7:0]  sbyte;
    logic signed [15:0] shalf;
    logic signed [31:0] sx;
    lane  = word >> {off, 3'b000};
    sbyte = lane[7:0];
    shalf = lane[15:0];
    case (op)
      OP_LB:   begin sx = sbyte; load_ext = sx; end
      OP_LBU:  load_ext = {24'd0, lane[7:0]};
      OP_LH:   begin sx = shalf; load_ext = sx; end
      OP_LHU:  load_ext = {16'd0, lane[15:0]};
      default: load_ext = word;
    endcase
  endfunction

  always_comb begin
    is_load    = (mem_op >= OP_LB) && (mem_op <= OP_LW);
    is_store   = (mem_op >= OP_SB) && (mem_op <= OP_SW);
    is_mem     = is_load || is_store;
    misaligned = 1'b0;
    case (mem_op)
      OP_LH, OP_LHU, OP_SH: misaligned = mem_addr[0];
      OP_LW, OP_SW:         misaligned = (mem_addr[1:0] != 2'b00);
      default:              misaligned = 1'b0;
    endcase
  end

  // Writeback and stall outputs: passthrough unless a memory op is in flight.
  always_comb begin
    wb_wd     = mem_wd;
    wb_wreg   = mem_wreg;
    wb_wdata  = mem_wdata;
    wb_whilo  = mem_whilo;
    wb_hi     = mem_hi;
    wb_lo     = mem_lo;
    stall_req = 1'b0;
    exc_adel  = 1'b0;
    exc_ades  = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          wb_wreg = 1'b0;
          if (misaligned) begin
            exc_adel = is_load;
            exc_ades = is_store;
          end else begin
            stall_req = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_req = 1'b1;
        wb_wreg   = 1'b0;
      end
      DONE: begin
        if (is_load) wb_wdata = load_ext(mem_op, mem_addr[1:0], rdata_q);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (is_mem && !misaligned) begin
          state_d     = BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store;
          bus_addr_d  = {mem_addr[31:2], 2'b00};
          bus_sel_d   = lane_sel(mem_op, mem_addr[1:0]);
          bus_wdata_d = is_store ? store_data(mem_op, mem_sdata) : 32'd0;
        end
      end
      BUSY: begin
        if (bus.bus_ack) begin
          rdata_d   = bus.bus_rdata;
          bus_req_d = 1'b0;
          state_d   = DONE;
        end
      end
      // DONE always retires, so a held instruction is never issued twice.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_sel_q   <= 4'd0;
      bus_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_sel   = bus_sel_q;
  assign bus.bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against an arithmetic reference model of the access rules.
module tb_mem_access;
  logic        clk;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi, mem_lo;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr, mem_sdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi, wb_lo;
  logic        stall_req, exc_adel, exc_ades;

  int n_checks = 0;
  int n_err    = 0;

  mem_access_if bif ();

  mem_access dut (
    .clk       (clk),
    .rst       (rst),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_whilo (mem_whilo),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .mem_op    (mem_op),
    .mem_addr  (mem_addr),
    .mem_sdata (mem_sdata),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata),
    .wb_whilo  (wb_whilo),
    .wb_hi     (wb_hi),
    .wb_lo     (wb_lo),
    .stall_req (stall_req),
    .exc_adel  (exc_adel),
    .exc_ades  (exc_ades),
    .bus       (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one instruction and follows it to completion, checking every cycle.
  task automatic run_txn(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata, input int n_ack);
    bit          ld, st, mis;
    int          size, off;
    longint      v, mask;
    logic [31:0] e_sel, e_wd, e_ld;

    ld   = (op >= 1 && op <= 5);
    st   = (op >= 6 && op <= 8);
    case (op)
      4'd1, 4'd2, 4'd6: size = 1;
      4'd3, 4'd4, 4'd7: size = 2;
      4'd5, 4'd8:       size = 4;
      default:          size = 0;
    endcase
    off  = int'(addr % 4);
    mis  = (size != 0) && ((addr % size) != 0);
    e_sel = 32'(((1 << size) - 1) << off);
    if (!st)           e_wd = 32'd0;
    else if (size == 1) e_wd = (sdata & 32'hFF) * 32'h01010101;
    else if (size == 2) e_wd = (sdata & 32'hFFFF) * 32'h00010001;
    else                e_wd = sdata;
    mask = (size == 0) ? 0 : (64'd1 << (8 * size)) - 1;
    v    = (longint'(rdata) >> (8 * off)) & mask;
    if ((op == 4'd1 || op == 4'd3) && v >= (64'd1 << (8 * size - 1)))
      v = v - (64'd1 << (8 * size));
    e_ld = 32'(v);

    @(posedge clk); #1;
    mem_op    = op;
    mem_addr  = addr;
    mem_sdata = sdata;
    mem_wd    = 5'($urandom);
    mem_wreg  = 1'($urandom);
    mem_wdata = $urandom;
    mem_whilo = 1'($urandom);
    mem_hi    = $urandom;
    mem_lo    = $urandom;
    @(negedge clk);
    chk("whilo", 32'(wb_whilo), 32'(mem_whilo));
    chk("hi", wb_hi, mem_hi);
    chk("lo", wb_lo, mem_lo);
    chk("wd", 32'(wb_wd), 32'(mem_wd));
    if (!ld && !st) begin
      chk("alu_wreg", 32'(wb_wreg), 32'(mem_wreg));
      chk("alu_wdata", wb_wdata, mem_wdata);
      chk("alu_stall", 32'(stall_req), 32'd0);
      chk("alu_exc", {30'd0, exc_adel, exc_ades}, 32'd0);
      chk("alu_req", 32'(bif.bus_req), 32'd0);
    end else if (mis) begin
      chk("mis_adel", 32'(exc_adel), 32'(ld));
      chk("mis_ades", 32'(exc_ades), 32'(st));
      chk("mis_wreg", 32'(wb_wreg), 32'd0);
      chk("mis_stall", 32'(stall_req), 32'd0);
      @(posedge clk); #1;
      chk("mis_req", 32'(bif.bus_req), 32'd0);
    end else begin
      chk("idle_stall", 32'(stall_req), 32'd1);
      chk("idle_wreg", 32'(wb_wreg), 32'd0);
      chk("idle_exc", {30'd0, exc_adel, exc_ades}, 32'd0);
      @(posedge clk); #1;
      chk("bus_req", 32'(bif.bus_req), 32'd1);
      chk("bus_we", 32'(bif.bus_we), 32'(st));
      chk("bus_addr", bif.bus_addr, addr & 32'hFFFF_FFFC);
      chk("bus_sel", 32'(bif.bus_sel), e_sel);
      chk("bus_wdata", bif.bus_wdata, e_wd);
      for (int k = 1; k <= n_ack; k++) begin
        if (k == n_ack) begin
          bif.bus_ack   = 1'b1;
          bif.bus_rdata = rdata;
        end
        @(negedge clk);
        chk("busy_stall", 32'(stall_req), 32'd1);
        chk("busy_wreg", 32'(wb_wreg), 32'd0);
        chk("busy_req", 32'(bif.bus_req), 32'd1);
        @(posedge clk); #1;
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = $urandom;
      end
      @(negedge clk);
      chk("done_stall", 32'(stall_req), 32'd0);
      chk("done_req", 32'(bif.bus_req), 32'd0);
      chk("done_wreg", 32'(wb_wreg), 32'(mem_wreg));
      chk("done_wdata", wb_wdata, ld ? e_ld : mem_wdata);
    end
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0; mem_whilo = 1'b0;
    mem_hi = '0; mem_lo = '0; mem_op = '0; mem_addr = '0; mem_sdata = '0;
    bif.bus_ack = 1'b0; bif.bus_rdata = '0;
    #2;
    chk("rst_req", 32'(bif.bus_req), 32'd0);
    chk("rst_we", 32'(bif.bus_we), 32'd0);
    chk("rst_addr", bif.bus_addr, 32'd0);
    chk("rst_sel", 32'(bif.bus_sel), 32'd0);
    chk("rst_wdata", bif.bus_wdata, 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_wb", {wb_wdata[30:0], wb_wreg}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fixed ALU passthrough
    @(posedge clk); #1;
    mem_op = 4'd0; mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'h1234;
    mem_whilo = 1'b1; mem_hi = 32'd5; mem_lo = 32'd6;
    #1;
    chk("pt_wd", 32'(wb_wd), 32'd3);
    chk("pt_wreg", 32'(wb_wreg), 32'd1);
    chk("pt_wdata", wb_wdata, 32'h1234);
    chk("pt_whilo", 32'(wb_whilo), 32'd1);
    chk("pt_hi", wb_hi, 32'd5);
    chk("pt_lo", wb_lo, 32'd6);
    chk("pt_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    chk("pt_req", 32'(bif.bus_req), 32'd0);

    run_txn(4'd1, 32'h1003, 32'h0, 32'h80AA55CC, 2);
    chk("lb_value", wb_wdata, 32'hFFFFFF80);
    run_txn(4'd4, 32'h2002, 32'h0, 32'hBEEF1234, 1);
    chk("lhu_value", wb_wdata, 32'h0000BEEF);
    run_txn(4'd6, 32'h3001, 32'h000000A5, 32'h0, 1);
    run_txn(4'd5, 32'h4002, 32'h0, 32'h0, 1);
    run_txn(4'd7, 32'h4001, 32'h1234, 32'h0, 1);

    // Reset during BUSY, then a stray ack
    @(posedge clk); #1;
    mem_op = 4'd5; mem_addr = 32'h5000; mem_wreg = 1'b1;
    @(posedge clk); #1;
    chk("mid_req_pre", 32'(bif.bus_req), 32'd1);
    rst = 1'b1; mem_op = 4'd0;
    #1;
    chk("mid_req_rst", 32'(bif.bus_req), 32'd0);
    chk("mid_addr_rst", bif.bus_addr, 32'd0);
    chk("mid_stall_rst", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    bif.bus_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_req", 32'(bif.bus_req), 32'd0);
    chk("late_ack_stall", 32'(stall_req), 32'd0);
    chk("late_ack_wdata", wb_wdata, mem_wdata);

    // Randomized mix with back-to-back ops
    for (int i = 0; i < 80; i++) begin
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      run_txn(4'($urandom_range(0, 15)), a, $urandom, $urandom, int'($urandom_range(1, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage sitting directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register. Passes ALU results and HI/LO writes through unchanged. Executes load/store instructions on a request/acknowledge data bus, raising a stall request until the access completes. Performs byte-lane selection, store-data replication, load extension and alignment checking.

## Interface
Parameters:
- none. Widths use the `RegBus` (32) and `RegAddrBus` (5) definitions.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- mem_wd  in  5  destination register from EX/MEM
- mem_wreg  in  1  register write enable from EX/MEM
- mem_wdata  in  32  ALU result from EX/MEM
- mem_whilo  in  1  HI/LO write enable
- mem_hi, mem_lo  in  32 each  HI/LO values
- mem_op  in  4  0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=SB, 7=SH, 8=SW; 9–15 treated as none
- mem_addr  in  32  effective address
- mem_sdata  in  32  store data (rt)
- wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo  out  5/1/32/1/32/32  to MEM/WB
- stall_req  out  1  hold all upstream stages and MEM/WB
- exc_adel, exc_ades  out  1  misaligned load / store address
- bus_req  out  1  access request (registered)
- bus_we  out  1  1 = write (registered)
- bus_addr  out  32  word address, low 2 bits forced to 0 (registered)
- bus_sel  out  4  byte enables, bit n = bits 8n+7:8n (registered)
- bus_wdata  out  32  write data (registered)
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  one-cycle completion strobe

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- Non-memory op (0, 9–15): all wb_* outputs equal the matching mem_* inputs combinationally. stall_req=0. The FSM stays in IDLE.
- Alignment check, evaluated in IDLE:
  - LH, LHU and SH require addr[0]=0.
  - LW and SW require addr[1:0]=0.
  - On a misaligned load, exc_adel=1. On a misaligned store, exc_ades=1.
  - In both cases wb_wreg=0, no bus access is made, stall_req=0, and the FSM stays in IDLE.
- Aligned memory op in IDLE:
  - stall_req=1 and wb_wreg=0.
  - At the clock edge, the FSM loads the bus registers and moves to BUSY.
  - bus_req=1, bus_we=1 for stores, bus_addr={addr[31:2],2'b00}.
- Byte lanes (little-endian):
  - Byte access: sel = 1<<addr[1:0].
  - Halfword access: sel = addr[1] ? 1100 : 0011.
  - Word access: sel = 1111.
  - SB writes {4{sdata[7:0]}], SH writes {2{sdata[15:0]}}, SW writes sdata.
  - For loads, bus_wdata=0.
- BUSY:
  - stall_req=1, wb_wreg=0, bus_* held.
  - On bus_ack, capture bus_rdata into rdata_q, drop bus_req, and move to DONE.
- DONE:
  - stall_req=0 and wb_wreg=mem_wreg.
  - For loads, wb_wdata is the selected lane of rdata_q, extended: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the full word.
  - For stores, wb_wdata=mem_wdata.
  - The FSM moves to IDLE unconditionally, so the same instruction is never re-issued.
- While stall_req=1, upstream holds all mem_* inputs stable. Behaviour under input changes during BUSY is undefined.
- wb_whilo, wb_hi and wb_lo always pass through, including for memory ops.

## Timing
- Reset (asynchronous, any state): FSM→IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_sel=0, bus_wdata=0, rdata_q=0.
  - Combinational outputs follow inputs. With zero inputs, all outputs are 0.
  - Reset during BUSY drops bus_req immediately. A late bus_ack is ignored.
- Latency of a memory op is 1 (IDLE) + N (BUSY, ack in the Nth cycle) + 1 (DONE) cycles.
  - The minimum is 3 cycles.
  - stall_req is high for N+1 cycles.
- bus_ack is accepted only in BUSY. An ack in IDLE or DONE is ignored.
- Back-to-back memory ops: after DONE, the next instruction is in IDLE on the following cycle. There is no idle bubble beyond the FSM sequence.
- Exception flags are combinational. They are asserted only in IDLE, for exactly as long as the misaligned op is presented.

## Test plan
- ALU op passthrough: mem_op=0, wd=3, wreg=1, wdata=0x1234, whilo=1, hi=5, lo=6 → identical wb_* in the same cycle; stall_req=0; bus_req stays 0.
- LB sign-extend:
  - Stimulus: addr=0x1003, ack in the 2nd BUSY cycle with rdata=0x80AA55CC.
  - Required: bus_addr=0x1000, sel=1000, stall_req high for 3 cycles.
  - DONE: wb_wdata=0xFFFFFF80, wb_wreg=1.
- LHU: addr=0x2002, rdata=0xBEEF1234 → sel=1100, wb_wdata=0x0000BEEF.
- SB: addr=0x3001, sdata=0x000000A5 → bus_we=1, sel=0010, bus_wdata=0xA5A5A5A5; 3-cycle access with immediate ack.
- Misaligned:
  - LW at addr=0x4002 → exc_adel=1, wb_wreg=0, no bus_req, stall_req=0.
  - SH at addr=0x4001 → exc_ades=1.
- Reset mid-access: assert rst during BUSY → bus_req=0 immediately, FSM in IDLE. An ack pulse after rst releases changes nothing.
